// File: rtl/dadda_product_accumulator.sv
// Accumulates a burst of unsigned multiplier products into a wide sum and hands the result downstream.
// Optional DADDA_ACC_SATURATE_EN: clamp the sum at all-ones on carry instead of wrapping.
module dadda_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   count;
  logic [LEN_W-1:0]   len_q;
  logic               ovf;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   next_acc;
  logic               take;
  logic               last;

  // One extra bit on the adder captures the carry that drives the sticky overflow flag.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

`ifdef DADDA_ACC_SATURATE_EN
  assign next_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign next_acc = sum[ACC_W-1:0];
`endif

  assign take = in_valid && (state == ACCUM);
  assign last = (count == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len != '0) begin
              len_q <= len;
              count <= '0;
              state <= ACCUM;
            end else begin
              state <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            acc   <= next_acc;
            ovf   <= ovf | sum[ACC_W];
            count <= count + LEN_W'(1);
            if (last) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The accumulator itself is the result register; it is frozen while the result is held.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

endmodule
